// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges single-cycle ALU results with queued long-latency results
// into one registered register-file write port. ALU always wins; others wait in a FIFO.
module wb_arbiter #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        aluWFlagIn,
    input  logic [4:0]  aluWAddrIn,
    input  logic [31:0] aluWDataIn,
    input  logic        lsuValidIn,
    input  logic [4:0]  lsuAddrIn,
    input  logic [31:0] lsuDataIn,
    output logic        lsuReadyOut,
    output logic        wFlagOut,
    output logic [4:0]  wAddrOut,
    output logic [31:0] wDataOut,
    output logic [31:0] pendingMaskOut,
    output logic        errOut
);

    localparam logic [PTR_W:0] CountFull = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [4:0]       fifo_addr_q [DEPTH];
    logic [31:0]      fifo_data_q [DEPTH];

    logic             w_flag_q, w_flag_d;
    logic [4:0]       w_addr_q, w_addr_d;
    logic [31:0]      w_data_q, w_data_d;
    logic             err_q, err_d;

    logic             alu_sel;
    logic             fifo_nonempty;
    logic             lsu_fire;
    logic             lsu_live;
    logic             deq;
    logic             enq;
    logic             bypass;
    logic [31:0]      pending_mask;

    assign alu_sel       = aluWFlagIn && (aluWAddrIn != 5'd0);
    assign fifo_nonempty = (count_q != '0);
    assign lsuReadyOut   = (count_q != CountFull);
    assign lsu_fire      = lsuValidIn && lsuReadyOut;
    // x0 results complete the handshake but are otherwise dropped
    assign lsu_live      = lsu_fire && (lsuAddrIn != 5'd0);
    assign deq           = !alu_sel && fifo_nonempty;
    assign bypass        = !alu_sel && !fifo_nonempty && lsu_live;
    assign enq           = lsu_live && (alu_sel || fifo_nonempty);

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (valid_q[i]) begin
                pending_mask[fifo_addr_q[i]] = 1'b1;
            end
        end
    end

    assign pendingMaskOut = pending_mask;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        count_d = count_q + {{PTR_W{1'b0}}, enq} - {{PTR_W{1'b0}}, deq};
        if (deq) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        if (enq) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_W'(1);
        end
    end

    always_comb begin
        w_flag_d = 1'b0;
        w_addr_d = w_addr_q;
        w_data_d = w_data_q;
        err_d    = err_q;
        if (alu_sel) begin
            w_flag_d = 1'b1;
            w_addr_d = aluWAddrIn;
            w_data_d = aluWDataIn;
        end else if (deq) begin
            w_flag_d = 1'b1;
            w_addr_d = fifo_addr_q[head_q];
            w_data_d = fifo_data_q[head_q];
        end else if (bypass) begin
            w_flag_d = 1'b1;
            w_addr_d = lsuAddrIn;
            w_data_d = lsuDataIn;
        end
        // The write still proceeds; decode should have stalled on the pending mask
        if (aluWFlagIn && pending_mask[aluWAddrIn]) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            w_flag_q <= 1'b0;
            w_addr_q <= 5'd0;
            w_data_q <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            w_flag_q <= w_flag_d;
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
            err_q    <= err_d;
        end
    end

    // Payload storage needs no reset; valid_q qualifies every entry
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_addr_q[tail_q] <= lsuAddrIn;
            fifo_data_q[tail_q] <= lsuDataIn;
        end
    end

    assign wFlagOut = w_flag_q;
    assign wAddrOut = w_addr_q;
    assign wDataOut = w_data_q;
    assign errOut   = err_q;

endmodule
